// File: rtl/glb_read_arbiter_pkg.sv
// Shared token-engine definitions: requester indices and the read-arbiter state encoding.
package glb_read_arbiter_pkg;

  localparam int unsigned REQ_IFMAP  = 0;
  localparam int unsigned REQ_FILTER = 1;
  localparam int unsigned REQ_IPSUM  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/glb_read_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after ptr, cyclically.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (grant == '0 && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/glb_read_arbiter.sv
// GLB read-port arbiter: round-robin grants with bounded bursts, per-cycle permits,
// and a per-requester data-valid delayed by the GLB read latency.
module glb_read_arbiter
  import glb_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        permit_o,
  output logic [NUM_REQ-1:0]        busy_o,
  output logic                      glb_re_o,
  output logic [ADDR_W-1:0]         glb_addr_o,
  input  logic [31:0]               glb_rdata_i,
  output logic [31:0]               rdata_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  arb_state_e          state, state_nx;
  logic [OW-1:0]       owner, owner_nx, rr_ptr, rr_nx, owner_inc, pick_idx;
  logic [CW-1:0]       burst, burst_nx;
  logic [NUM_REQ-1:0]  pick_grant, owner_oh;
  logic [NUM_REQ-1:0]  vld_sr [RD_LAT];
  logic                req_own;
  logic [ADDR_W-1:0]   addr_own;

  rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    req_own  = 1'b0;
    addr_own = '0;
    owner_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner == OW'(k)) begin
        req_own     = req_i[k];
        addr_own    = addr_i[k*ADDR_W +: ADDR_W];
        owner_oh[k] = 1'b1;
      end
    end
    owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    rr_nx      = rr_ptr;
    burst_nx   = burst;
    permit_o   = '0;
    busy_o     = '0;
    glb_addr_o = '0;
    case (state)
      IDLE: begin
        if (|pick_grant) begin
          state_nx = GRANT;
          owner_nx = pick_idx;
          burst_nx = '0;
        end
      end
      GRANT: begin
        busy_o     = ~owner_oh;
        glb_addr_o = addr_own;
        if (!req_own) begin
          state_nx = IDLE;
          rr_nx    = owner_inc;
        end else begin
          permit_o = owner_oh;
          if (burst == CW'(BURST_MAX - 1)) begin
            state_nx = IDLE;
            rr_nx    = owner_inc;
          end
          burst_nx = burst + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Flush overrides the normal decisions above but leaves rr_ptr and owner alone.
    if (flush_i) begin
      state_nx = IDLE;
      owner_nx = owner;
      rr_nx    = rr_ptr;
      burst_nx = '0;
      permit_o = '0;
    end
  end

  assign glb_re_o = |permit_o;
  assign rdata_o  = glb_rdata_i;
  assign owner_o  = owner;
  assign rvalid_o = flush_i ? '0 : vld_sr[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      burst  <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
      burst  <= burst_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) vld_sr[i] <= '0;
    end else begin
      vld_sr[0] <= permit_o;
      for (int unsigned i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

endmodule

// File: tb/tb_glb_read_arbiter.sv
// Directed table-driven bench for glb_read_arbiter (RD_LAT=1 and RD_LAT=2 instances).
module tb_glb_read_arbiter;

  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] A2 = 32'h8000_0300;
  localparam logic [31:0] DOFS = 32'h1000_0000;

  logic        clk, rst_n, flush;
  logic [2:0]  req;
  logic [31:0] a0;
  logic [95:0] addr;

  logic [2:0]  p1, b1, v1, p2, b2, v2;
  logic        re1, re2;
  logic [31:0] ad1, ad2, rd1, rd2, gd1, gd2a, gd2b;
  logic [1:0]  o1, o2;

  int ncmp = 0;
  int nfail = 0;

  assign addr = {A2, A1, a0};

  glb_read_arbiter #(.NUM_REQ(3), .ADDR_W(32), .BURST_MAX(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_i(req), .addr_i(addr),
    .permit_o(p1), .busy_o(b1), .glb_re_o(re1), .glb_addr_o(ad1),
    .glb_rdata_i(gd1), .rdata_o(rd1), .rvalid_o(v1), .owner_o(o1));

  glb_read_arbiter #(.NUM_REQ(3), .ADDR_W(32), .BURST_MAX(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_i(req), .addr_i(addr),
    .permit_o(p2), .busy_o(b2), .glb_re_o(re2), .glb_addr_o(ad2),
    .glb_rdata_i(gd2b), .rdata_o(rd2), .rvalid_o(v2), .owner_o(o2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB model: data = address + DOFS, returned after each instance's read latency.
  initial begin gd1 = '0; gd2a = '0; gd2b = '0; end
  always @(posedge clk) begin
    gd1  <= re1 ? ad1 + DOFS : '0;
    gd2a <= re2 ? ad2 + DOFS : '0;
    gd2b <= gd2a;
  end

  typedef struct {
    bit rst; bit sel2; logic [2:0] req; bit fl; logic [31:0] a0;
    logic [2:0] p; logic [2:0] bz; logic [31:0] ad; logic [2:0] rv; logic [1:0] own;
    bit crd; logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit sel2, logic [2:0] rq, bit fl, logic [31:0] x0,
                              logic [2:0] p, logic [2:0] bz, logic [31:0] ad, logic [2:0] rv,
                              logic [1:0] own, bit crd, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.sel2 = sel2; v.req = rq; v.fl = fl; v.a0 = x0; v.p = p; v.bz = bz;
    v.ad = ad; v.rv = rv; v.own = own; v.crd = crd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  vec_t v;
  logic [2:0]  ap, ab, av;
  logic        are;
  logic [31:0] aad, ard;
  logic [1:0]  aown;

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = '0; a0 = '0;
    #1;
    chk("rst_permit", -1, 32'(p1), 0);
    chk("rst_busy", -1, 32'(b1), 0);
    chk("rst_re", -1, 32'(re1), 0);
    chk("rst_addr", -1, ad1, 0);
    chk("rst_rvalid", -1, 32'(v1), 0);
    chk("rst_owner", -1, 32'(o1), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: ifmap alone, 0x100..0x107, two bursts of 4 with a bubble
    tbl.push_back(mk(1,0,3'b001,0,32'h100, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h100, 3'b001,3'b110,32'h100, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h101, 3'b001,3'b110,32'h101, 3'b001,0,1,32'h1000_0100));
    tbl.push_back(mk(0,0,3'b001,0,32'h102, 3'b001,3'b110,32'h102, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h103, 3'b001,3'b110,32'h103, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h104, 3'b000,3'b000,32'h0,   3'b001,0,1,32'h1000_0103));
    tbl.push_back(mk(0,0,3'b001,0,32'h104, 3'b001,3'b110,32'h104, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h105, 3'b001,3'b110,32'h105, 3'b001,0,1,32'h1000_0104));
    tbl.push_back(mk(0,0,3'b001,0,32'h106, 3'b001,3'b110,32'h106, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h107, 3'b001,3'b110,32'h107, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b000,0,32'h107, 3'b000,3'b000,32'h0,   3'b001,0,1,32'h1000_0107));
    // 2: all three continuously; ipsum address has bit 31 set
    tbl.push_back(mk(1,0,3'b111,0,32'h110, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b001,3'b110,32'h110, (i==0)?3'b000:3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b000,3'b000,32'h0,   3'b001,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b010,3'b101,A1,     (i==0)?3'b000:3'b010,1,0,0));
    tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b000,3'b000,32'h0,   3'b010,1,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b100,3'b011,A2,     (i==0)?3'b000:3'b100,2,0,0));
    tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b000,3'b000,32'h0,   3'b100,2,0,0));
    tbl.push_back(mk(0,0,3'b111,0,32'h110, 3'b001,3'b110,32'h110, 3'b000,0,0,0));
    // 3: filter 2 beats then drops; ipsum and ifmap pending, ipsum wins next
    tbl.push_back(mk(1,0,3'b110,0,32'h120, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b110,0,32'h120, 3'b010,3'b101,A1,      3'b000,1,0,0));
    tbl.push_back(mk(0,0,3'b110,0,32'h120, 3'b010,3'b101,A1,      3'b010,1,0,0));
    tbl.push_back(mk(0,0,3'b101,0,32'h120, 3'b000,3'b101,A1,      3'b010,1,0,0));
    tbl.push_back(mk(0,0,3'b101,0,32'h120, 3'b000,3'b000,32'h0,   3'b000,1,0,0));
    tbl.push_back(mk(0,0,3'b101,0,32'h120, 3'b100,3'b011,A2,      3'b000,2,0,0));
    tbl.push_back(mk(0,0,3'b000,0,32'h120, 3'b000,3'b011,A2,      3'b100,2,0,0));
    tbl.push_back(mk(0,0,3'b000,0,32'h120, 3'b000,3'b000,32'h0,   3'b000,2,0,0));
    // 4: flush on the 3rd ifmap beat; later burst is a full 4 beats
    tbl.push_back(mk(1,0,3'b001,0,32'h140, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h140, 3'b001,3'b110,32'h140, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b001,0,32'h141, 3'b001,3'b110,32'h141, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b011,1,32'h142, 3'b000,3'b110,32'h142, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h142, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h142, 3'b001,3'b110,32'h142, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h143, 3'b001,3'b110,32'h143, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h144, 3'b001,3'b110,32'h144, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h145, 3'b001,3'b110,32'h145, 3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h146, 3'b000,3'b000,32'h0,   3'b001,0,0,0));
    tbl.push_back(mk(0,0,3'b011,0,32'h146, 3'b010,3'b101,A1,      3'b000,1,0,0));
    // 6: RD_LAT=2 instance, alternating single-beat requests
    tbl.push_back(mk(1,1,3'b001,0,32'h180, 3'b000,3'b000,32'h0,   3'b000,0,0,0));
    tbl.push_back(mk(0,1,3'b001,0,32'h180, 3'b001,3'b110,32'h180, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,3'b010,0,32'h180, 3'b000,3'b110,32'h180, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,3'b010,0,32'h180, 3'b000,3'b000,32'h0,   3'b001,0,1,32'h1000_0180));
    tbl.push_back(mk(0,1,3'b010,0,32'h180, 3'b010,3'b101,A1,      3'b000,1,0,0));
    tbl.push_back(mk(0,1,3'b001,0,32'h184, 3'b000,3'b101,A1,      3'b000,1,0,0));
    tbl.push_back(mk(0,1,3'b001,0,32'h184, 3'b000,3'b000,32'h0,   3'b010,1,1,32'h1000_0200));
    tbl.push_back(mk(0,1,3'b001,0,32'h184, 3'b001,3'b110,32'h184, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,3'b000,0,32'h184, 3'b000,3'b110,32'h184, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,3'b000,0,32'h184, 3'b000,3'b000,32'h0,   3'b001,0,1,32'h1000_0184));
    tbl.push_back(mk(0,1,3'b000,0,32'h184, 3'b000,3'b000,32'h0,   3'b000,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.rst) begin rst_n = 1'b0; #2; rst_n = 1'b1; end
      req = v.req; flush = v.fl; a0 = v.a0;
      @(negedge clk);
      if (v.sel2) begin ap = p2; ab = b2; are = re2; aad = ad2; av = v2; aown = o2; ard = rd2; end
      else        begin ap = p1; ab = b1; are = re1; aad = ad1; av = v1; aown = o1; ard = rd1; end
      chk("permit", i, 32'(ap), 32'(v.p));
      chk("busy",   i, 32'(ab), 32'(v.bz));
      chk("glb_re", i, 32'(are), 32'(|v.p));
      chk("glb_addr", i, aad, v.ad);
      chk("rvalid", i, 32'(av), 32'(v.rv));
      chk("owner",  i, 32'(aown), 32'(v.own));
      if (v.crd) chk("rdata", i, ard, v.rd);
      @(posedge clk); #1;
    end

    // 5: asynchronous reset in the middle of an ifmap burst
    flush = 1'b0; req = 3'b001; a0 = 32'h1C0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_permit_pre", 900, 32'(p1), 32'h1);
    @(posedge clk); #1;
    chk("t5_permit_mid", 901, 32'(p1), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_permit", 902, 32'(p1), 0);
    chk("t5_busy",   902, 32'(b1), 0);
    chk("t5_re",     902, 32'(re1), 0);
    chk("t5_addr",   902, ad1, 0);
    chk("t5_rvalid", 902, 32'(v1), 0);
    chk("t5_owner",  902, 32'(o1), 0);
    req = 3'b110;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_permit", 903, 32'(p1), 0);
    chk("t5_idle_rvalid", 903, 32'(v1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_regrant_permit", 904, 32'(p1), 32'h2);
    chk("t5_regrant_owner",  904, 32'(o1), 32'h1);
    chk("t5_regrant_rvalid", 904, 32'(v1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_rvalid_post", 905, 32'(v1), 32'h2);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/glb_read_arbiter.md
Name: glb_read_arbiter

Overview:
- Shares the single GLB read port among the token-engine FIFO controllers: ifmap, filter and ipsum.
- Each controller raises a read request carrying an address. The arbiter grants one requester at a time with round-robin fairness and a bounded burst length.
- A granted requester gets a per-cycle permit, the GLB address/enable is muxed from it, and a per-requester data-valid is returned after the fixed GLB read latency.
- The arbiter also drives each controller's "GLB busy" indication. It sits between the FIFO controllers and the GLB read port.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = ifmap, 1 = filter, 2 = ipsum)
- ADDR_W, 32, GLB byte-address width
- BURST_MAX, 4, maximum permits per grant before forced re-arbitration
- RD_LAT, 1, GLB read latency in cycles, from read enable to data

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of the current grant and in-flight returns
- req_i  in  NUM_REQ  read request per requester
- addr_i  in  NUM_REQ*ADDR_W  per-requester read address, slice k = requester k
- permit_o  out  NUM_REQ  one-hot; address of requester k is issued this cycle
- busy_o  out  NUM_REQ  bit k high = port currently owned by another requester
- glb_re_o  out  1  GLB read enable
- glb_addr_o  out  ADDR_W  GLB read address
- glb_rdata_i  in  32  GLB read data, valid RD_LAT cycles after glb_re_o
- rdata_o  out  32  glb_rdata_i passed through combinationally, broadcast to all requesters
- rvalid_o  out  NUM_REQ  bit k high = rdata_o belongs to requester k this cycle
- owner_o  out  $clog2(NUM_REQ)  current/last owner index, for debug

Behaviour:
Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.

Reset values:
- state = IDLE; owner, rr_ptr, burst_cnt = 0; valid shift register cleared.
- All outputs 0, except rdata_o, which follows glb_rdata_i.

FSM state IDLE:
- If any req_i bit is set, pick the first requester at or after rr_ptr (cyclic).
- Register it as owner, clear burst_cnt, go to GRANT.
- No permit is issued in IDLE, so arbitration costs 1 cycle.

FSM state GRANT:
- permit_o[owner] = req_i[owner]. This is combinational, and no other bit of permit_o may be set.
- glb_re_o = |permit_o; glb_addr_o = addr_i[owner]. When no permit is issued, glb_addr_o holds the owner's address (don't-care for the GLB).
- burst_cnt increments on every permit.
- Exit to IDLE when req_i[owner] is low (no permit that cycle), or when a permit is issued with burst_cnt == BURST_MAX-1.
- On exit, rr_ptr = (owner+1) mod NUM_REQ.

busy_o:
- busy_o[k] = (state==GRANT) && (owner != k).
- busy_o is 0 in IDLE.

Data return:
- An RD_LAT-deep shift register carries the one-hot permit_o; its output is rvalid_o.
- rvalid_o therefore pulses exactly RD_LAT cycles after each permit, same order, no loss or duplication.
- Throughput: one read per cycle inside a grant, back-to-back.

Boundary cases:
- Owner still requesting at burst end: IDLE re-arbitrates. It is regranted only if no other requester is pending; there is 1 bubble cycle.
- Owner drops its request mid-burst: the grant is released that cycle with no permit.
- A requester that deasserts in the IDLE cycle after selection still receives a GRANT, which then exits with no permit.
- flush_i: takes priority over everything. Next state is IDLE, burst_cnt = 0, shift register cleared (pending rvalid suppressed), rr_ptr unchanged. permit_o and glb_re_o are forced to 0 in the flush cycle.
- Reset mid-burst: immediate return to reset values. No rvalid is emitted afterward for pre-reset permits.
- Address arithmetic: none, pure mux. Addresses with bit ADDR_W-1 set (the padding region) are forwarded unchanged; zeroing the data is the requester's job.

Decomposition:
- Shared package (token-engine package): requester index constants REQ_IFMAP=0, REQ_FILTER=1, REQ_IPSUM=2, and the arbiter state enum (IDLE, GRANT).
- One natural sub-module: rr_pick, a combinational round-robin priority encoder (req vector plus pointer in, one-hot winner and index out). It is reused by the output-side write arbiter.

Test Plan:
1. Only ifmap requests, continuously, with addresses 0x100..0x107.
   - Required: permit on cycles 1-4, a bubble, then permits again.
   - glb_addr_o follows the addresses; rvalid_o[0] arrives 1 cycle after each permit, 8 total.
2. All three request continuously from reset.
   - Required grant order ifmap×4, filter×4, ipsum×4, ifmap…
   - busy_o[1] and busy_o[2] are high throughout ifmap's grant.
3. Filter requests 2 beats, then drops; ipsum is pending.
   - Required: exactly 2 filter permits, release in the drop cycle, ipsum granted 1 cycle later.
   - rr_ptr advances past filter.
4. flush_i asserted on the 3rd beat of an ifmap burst.
   - Required: no permit in that cycle; rvalid_o for the 2nd beat suppressed; state IDLE the next cycle.
5. rst_n pulled low mid-burst.
   - Required: all outputs 0 asynchronously; after release, the first grant goes to the lowest pending index.
6. RD_LAT=2 build, alternating single-beat requests.
   - Required: each rvalid_o bit is one-hot and lags its permit by exactly 2 cycles.
   - rdata_o equals the GLB model data for that address.
